// File: rtl/avr_dmem_bank_ctrl_if.sv
// Data-memory bus bundle between the AVR core data port and the bank controller.
//   core side : cp2en, ramadr, ramre, ramwe, dbusout -> controller; dbusin, rd_valid, cpuwait <- controller
//   bank side : bank_cen, bank_wen, bank_a, bank_d <- controller; bank_q -> controller
//   optional  : err_clr, err_flag, err_addr, err_cnt when DMEM_ERR_LOG_EN is defined
// slave modport is taken by the controller, master by the core/bench side.
interface avr_dmem_bank_ctrl_if #(
  parameter int unsigned BANK_AW   = 11,
  parameter int unsigned NUM_BANKS = 2
);
  logic                     cp2en;
  logic [15:0]              ramadr;
  logic                     ramre;
  logic                     ramwe;
  logic [7:0]               dbusout;
  logic [7:0]               dbusin;
  logic                     rd_valid;
  logic                     cpuwait;
  logic [NUM_BANKS-1:0]     bank_cen;
  logic                     bank_wen;
  logic [BANK_AW-1:0]       bank_a;
  logic [7:0]               bank_d;
  logic [8*NUM_BANKS-1:0]   bank_q;
`ifdef DMEM_ERR_LOG_EN
  logic                     err_clr;
  logic                     err_flag;
  logic [15:0]              err_addr;
  logic [7:0]               err_cnt;
`endif

  modport slave (
    input  cp2en, ramadr, ramre, ramwe, dbusout, bank_q,
    output dbusin, rd_valid, cpuwait, bank_cen, bank_wen, bank_a, bank_d
`ifdef DMEM_ERR_LOG_EN
    , input err_clr
    , output err_flag, err_addr, err_cnt
`endif
  );

  modport master (
    output cp2en, ramadr, ramre, ramwe, dbusout, bank_q,
    input  dbusin, rd_valid, cpuwait, bank_cen, bank_wen, bank_a, bank_d
`ifdef DMEM_ERR_LOG_EN
    , output err_clr
    , input err_flag, err_addr, err_cnt
`endif
  );
endinterface

// File: rtl/avr_dmem_bank_ctrl.sv
// AVR data-memory controller: decodes the SRAM window at RAM_BASE, picks one of
// NUM_BANKS single-port SRAM macros, rebases the address and sequences each
// access (IDLE -> ACCESS [-> WAIT -> DONE]), stalling the core on reads.
// Ports:
//   cp2     : clock (banks share the rising edge)
//   ireset  : asynchronous reset, active-high
//   bus     : avr_dmem_bank_ctrl_if.slave (core data bus + shared bank bus)
// Optional feature macro: DMEM_ERR_LOG_EN adds a sticky out-of-range error log
// (err_flag/err_addr/err_cnt, cleared by err_clr).
module avr_dmem_bank_ctrl #(
  parameter int unsigned RAM_BASE    = 256,
  parameter int unsigned BANK_AW     = 11,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic                 cp2,
  input logic                 ireset,
  avr_dmem_bank_ctrl_if.slave bus
);

  localparam int unsigned BANK_SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned RAM_END    = RAM_BASE + NUM_BANKS * (2 ** BANK_AW);
  localparam int unsigned CNT_W      = 3;

  // Elaboration-time parameter checks.
  if (WAIT_STATES == 0 || WAIT_STATES > 7) begin : g_bad_wait_states
    $error("avr_dmem_bank_ctrl: WAIT_STATES must be in 1..7");
  end
  if (NUM_BANKS == 0 || NUM_BANKS > 8) begin : g_bad_num_banks
    $error("avr_dmem_bank_ctrl: NUM_BANKS must be in 1..8");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                 state_q,    state_d;
  logic [BANK_SEL_W-1:0]  bank_sel_q, bank_sel_d;
  logic                   we_q,       we_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic [NUM_BANKS-1:0]   bank_cen_q, bank_cen_d;
  logic                   bank_wen_q, bank_wen_d;
  logic [BANK_AW-1:0]     bank_a_q,   bank_a_d;
  logic [7:0]             bank_d_q,   bank_d_d;
  logic [7:0]             dbusin_q,   dbusin_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   cpuwait_c;

  // Address decode; 17-bit compare so the window end cannot wrap past 16'hFFFF.
  logic [16:0]            adr_ext;
  logic                   in_range_c;
  logic [15:0]            off_c;
  logic [BANK_SEL_W-1:0]  bank_c;
  logic [BANK_AW-1:0]     addr_c;
  logic                   req_c;
  logic [7:0]             rd_sel_c;

  assign adr_ext    = {1'b0, bus.ramadr};
  assign in_range_c = (adr_ext >= 17'(RAM_BASE)) && (adr_ext < 17'(RAM_END));
  assign off_c      = bus.ramadr - 16'(RAM_BASE);
  assign bank_c     = BANK_SEL_W'(off_c >> BANK_AW);
  assign addr_c     = BANK_AW'(off_c);
  assign req_c      = bus.cp2en & (bus.ramre | bus.ramwe) & in_range_c;

  // Read-data mux for the bank latched at accept time.
  always_comb begin
    rd_sel_c = '0;
    for (int i = 0; i < int'(NUM_BANKS); i++) begin
      if (bank_sel_q == BANK_SEL_W'(i)) rd_sel_c = bus.bank_q[8*i +: 8];
    end
  end

  // Next-state and output computation.
  always_comb begin
    state_d    = state_q;
    bank_sel_d = bank_sel_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    bank_cen_d = '1;
    bank_wen_d = 1'b1;
    bank_a_d   = bank_a_q;
    bank_d_d   = bank_d_q;
    dbusin_d   = dbusin_q;
    rd_valid_d = 1'b0;
    cpuwait_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_c) begin
          state_d    = S_ACCESS;
          bank_sel_d = bank_c;
          we_d       = bus.ramwe;
          bank_a_d   = addr_c;
          bank_d_d   = bus.dbusout;
          bank_wen_d = ~bus.ramwe;
          for (int i = 0; i < int'(NUM_BANKS); i++) begin
            if (bank_c == BANK_SEL_W'(i)) bank_cen_d[i] = 1'b0;
          end
          // Writes complete without a stall; reads hold the core from this cycle.
          cpuwait_c  = ~bus.ramwe;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d   = S_IDLE;
          // A request arriving while the write is still on the bank must wait a cycle.
          cpuwait_c = req_c;
        end else begin
          state_d   = S_WAIT;
          cnt_d     = CNT_W'(WAIT_STATES);
          cpuwait_c = 1'b1;
        end
      end
      S_WAIT: begin
        cpuwait_c = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_DONE;
          dbusin_d   = rd_sel_c;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // ramre still belongs to the completed read, so nothing is accepted here.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      state_q    <= S_IDLE;
      bank_sel_q <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      bank_cen_q <= '1;
      bank_wen_q <= 1'b1;
      bank_a_q   <= '0;
      bank_d_q   <= '0;
      dbusin_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_sel_q <= bank_sel_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      bank_cen_q <= bank_cen_d;
      bank_wen_q <= bank_wen_d;
      bank_a_q   <= bank_a_d;
      bank_d_q   <= bank_d_d;
      dbusin_q   <= dbusin_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // The stall is combinational from state; reset forces it low immediately.
  assign bus.cpuwait  = cpuwait_c & ~ireset;
  assign bus.dbusin   = dbusin_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.bank_cen = bank_cen_q;
  assign bus.bank_wen = bank_wen_q;
  assign bus.bank_a   = bank_a_q;
  assign bus.bank_d   = bank_d_q;

`ifdef DMEM_ERR_LOG_EN
  // Sticky log of accesses above the window (below RAM_BASE is I/O space, not an error).
  logic        err_flag_q, err_flag_d;
  logic [15:0] err_addr_q, err_addr_d;
  logic [7:0]  err_cnt_q,  err_cnt_d;
  logic        fault_c;

  assign fault_c = bus.cp2en & (bus.ramre | bus.ramwe) & ~in_range_c &
                   (adr_ext >= 17'(RAM_BASE));

  always_comb begin
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (bus.err_clr) begin
      err_flag_d = 1'b0;
      err_addr_d = '0;
      err_cnt_d  = '0;
    end else if (fault_c) begin
      err_flag_d = 1'b1;
      if (!err_flag_q) err_addr_d = bus.ramadr;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.err_flag = err_flag_q;
  assign bus.err_addr = err_addr_q;
  assign bus.err_cnt  = err_cnt_q;
`else
  // Out-of-range accesses are silently dropped.
`endif

endmodule

// File: tb/tb_avr_dmem_bank_ctrl.sv
// Self-checking bench for avr_dmem_bank_ctrl: a default instance (WAIT_STATES=1)
// carries the directed and random traffic, a second instance checks WAIT_STATES=3.
// Expected stalls, read data and bank strobes come from a byte-addressed
// reference memory and the transaction-level timing rules.
module tb_avr_dmem_bank_ctrl;

  localparam int unsigned WS0 = 1;
  localparam int unsigned WS1 = 3;

  logic cp2;
  logic ireset;

  int total = 0;
  int bad   = 0;

  avr_dmem_bank_ctrl_if #(.BANK_AW(11), .NUM_BANKS(2)) ifc0 ();
  avr_dmem_bank_ctrl_if #(.BANK_AW(11), .NUM_BANKS(2)) ifc1 ();

  avr_dmem_bank_ctrl #(.RAM_BASE(256), .BANK_AW(11), .NUM_BANKS(2), .WAIT_STATES(WS0))
    u_dut0 (.cp2(cp2), .ireset(ireset), .bus(ifc0));
  avr_dmem_bank_ctrl #(.RAM_BASE(256), .BANK_AW(11), .NUM_BANKS(2), .WAIT_STATES(WS1))
    u_dut1 (.cp2(cp2), .ireset(ireset), .bus(ifc1));

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  // Behavioural SRAM macros for each instance.
  logic [7:0] mem0 [0:1][0:2047];
  logic [7:0] mem1 [0:1][0:2047];
  logic [7:0] q0 [0:1];
  logic [7:0] q1 [0:1];
  logic       mem_init = 1'b0;

  always @(posedge cp2) begin
    if (!mem_init) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 2048; a++) begin
          mem0[b][a] <= 8'h00;
          mem1[b][a] <= 8'h00;
        end
      mem_init <= 1'b1;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (ifc0.bank_cen[b] == 1'b0) begin
          if (ifc0.bank_wen == 1'b0) mem0[b][ifc0.bank_a] <= ifc0.bank_d;
          else                       q0[b] <= mem0[b][ifc0.bank_a];
        end
        if (ifc1.bank_cen[b] == 1'b0) begin
          if (ifc1.bank_wen == 1'b0) mem1[b][ifc1.bank_a] <= ifc1.bank_d;
          else                       q1[b] <= mem1[b][ifc1.bank_a];
        end
      end
    end
  end

  assign ifc0.bank_q = {q0[1], q0[0]};
  assign ifc1.bank_q = {q1[1], q1[0]};

  // Reference model state (instance 0).
  logic [7:0] ref_mem [int];
  logic [7:0] last_rd;
  logic       prev_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core-like access: hold the strobes until cpuwait drops, then sample the data.
  task automatic do_access(input int inst, input logic [15:0] adr, input logic re,
                           input logic we, input logic [7:0] wd, input logic en,
                           output int stall, output logic [7:0] rd,
                           output logic rv, output logic ok);
    logic w;
    if (inst == 0) begin
      ifc0.ramadr = adr; ifc0.ramre = re; ifc0.ramwe = we; ifc0.dbusout = wd; ifc0.cp2en = en;
    end else begin
      ifc1.ramadr = adr; ifc1.ramre = re; ifc1.ramwe = we; ifc1.dbusout = wd; ifc1.cp2en = en;
    end
    stall = 0; ok = 1'b0; rd = '0; rv = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge cp2);
      w = (inst == 0) ? ifc0.cpuwait : ifc1.cpuwait;
      if (w !== 1'b1) begin
        ok = 1'b1;
        rd = (inst == 0) ? ifc0.dbusin : ifc1.dbusin;
        rv = (inst == 0) ? ifc0.rd_valid : ifc1.rd_valid;
      end else begin
        stall++;
      end
      @(posedge cp2); #1;
      if (ok) break;
    end
    if (inst == 0) begin ifc0.ramre = 1'b0; ifc0.ramwe = 1'b0; end
    else           begin ifc1.ramre = 1'b0; ifc1.ramwe = 1'b0; end
  endtask

  // One transaction on instance 0, checked against the reference model.
  task automatic txn(input logic [15:0] adr, input logic re, input logic we,
                     input logic [7:0] wd, input logic en, input string tag);
    int         exp_stall;
    logic       inr, is_req, is_rd;
    logic [7:0] exp_d;
    logic       exp_v;
    int         stall;
    logic [7:0] rd;
    logic       rv, ok;
    inr       = (int'(adr) >= 256) && (int'(adr) < 256 + 2 * 2048);
    is_req    = en && (re || we) && inr;
    is_rd     = is_req && !we;
    exp_stall = (is_req && prev_wr) ? 1 : 0;
    if (is_rd) exp_stall += 2 + int'(WS0);
    do_access(0, adr, re, we, wd, en, stall, rd, rv, ok);
    chk({tag, "_done"}, 32'(ok), 32'd1);
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    if (is_rd) begin
      exp_d   = ref_mem.exists(int'(adr)) ? ref_mem[int'(adr)] : 8'h00;
      exp_v   = 1'b1;
      last_rd = exp_d;
    end else begin
      exp_d = last_rd;
      exp_v = 1'b0;
    end
    chk({tag, "_dbusin"}, 32'(rd), 32'(exp_d));
    chk({tag, "_rd_valid"}, 32'(rv), 32'(exp_v));
    if (is_req && we) ref_mem[int'(adr)] = wd;
    prev_wr = is_req && we;
  endtask

  // Check the bank strobes in the ACCESS cycle following a write accept.
  task automatic check_access(input string tag, input logic [1:0] cen,
                              input logic [10:0] a, input logic wen, input logic [7:0] d);
    @(negedge cp2);
    chk({tag, "_cen"}, 32'(ifc0.bank_cen), 32'(cen));
    chk({tag, "_a"},   32'(ifc0.bank_a),   32'(a));
    chk({tag, "_wen"}, 32'(ifc0.bank_wen), 32'(wen));
    chk({tag, "_d"},   32'(ifc0.bank_d),   32'(d));
    @(posedge cp2); #1;
    prev_wr = 1'b0;
  endtask

  initial begin
    logic [15:0] adr;
    logic [7:0]  wd;
    logic        re, we, en;
    int          r, kind, stall;
    logic [7:0]  rd;
    logic        rv, ok;

    ireset = 1'b1;
    ifc0.cp2en = 1'b0; ifc0.ramadr = '0; ifc0.ramre = 1'b0; ifc0.ramwe = 1'b0; ifc0.dbusout = '0;
    ifc1.cp2en = 1'b0; ifc1.ramadr = '0; ifc1.ramre = 1'b0; ifc1.ramwe = 1'b0; ifc1.dbusout = '0;
`ifdef DMEM_ERR_LOG_EN
    ifc0.err_clr = 1'b0;
    ifc1.err_clr = 1'b0;
`endif
    last_rd = 8'h00;
    prev_wr = 1'b0;

    // Reset values.
    @(negedge cp2);
    chk("rst_cpuwait",  32'(ifc0.cpuwait),  32'd0);
    chk("rst_rd_valid", 32'(ifc0.rd_valid), 32'd0);
    chk("rst_dbusin",   32'(ifc0.dbusin),   32'h00);
    chk("rst_cen",      32'(ifc0.bank_cen), 32'h3);
    chk("rst_wen",      32'(ifc0.bank_wen), 32'd1);
    chk("rst_a",        32'(ifc0.bank_a),   32'd0);
    chk("rst_d",        32'(ifc0.bank_d),   32'd0);
    @(posedge cp2); @(posedge cp2); #1;
    ireset = 1'b0;
    @(posedge cp2); #1;

    // Write then read with defaults.
    txn(16'h0100, 1'b0, 1'b1, 8'hA5, 1'b1, "wr0100");
    check_access("wr0100_acc", 2'b10, 11'h000, 1'b0, 8'hA5);
    txn(16'h0100, 1'b1, 1'b0, 8'h00, 1'b1, "rd0100");

    // Bank boundary.
    txn(16'h08FF, 1'b0, 1'b1, 8'h11, 1'b1, "wr08FF");
    check_access("wr08FF_acc", 2'b10, 11'h7FF, 1'b0, 8'h11);
    txn(16'h0900, 1'b0, 1'b1, 8'h22, 1'b1, "wr0900");
    check_access("wr0900_acc", 2'b01, 11'h000, 1'b0, 8'h22);
    txn(16'h08FF, 1'b1, 1'b0, 8'h00, 1'b1, "rd08FF");
    txn(16'h0900, 1'b1, 1'b0, 8'h00, 1'b1, "rd0900");

    // Out of range: no stall, no bank activity.
    txn(16'h00FF, 1'b1, 1'b0, 8'h00, 1'b1, "rd00FF");
    @(negedge cp2); chk("rd00FF_cen", 32'(ifc0.bank_cen), 32'h3); @(posedge cp2); #1;
    txn(16'h1100, 1'b1, 1'b0, 8'h00, 1'b1, "rd1100");
    @(negedge cp2); chk("rd1100_cen", 32'(ifc0.bank_cen), 32'h3); @(posedge cp2); #1;
`ifdef DMEM_ERR_LOG_EN
    chk("err_flag", 32'(ifc0.err_flag), 32'd1);
    chk("err_addr", 32'(ifc0.err_addr), 32'h1100);
    chk("err_cnt",  32'(ifc0.err_cnt),  32'd1);
    ifc0.err_clr = 1'b1; @(posedge cp2); #1; ifc0.err_clr = 1'b0;
    chk("err_clr_cnt", 32'(ifc0.err_cnt), 32'd0);
`endif

    // ramre and ramwe together act as a write.
    txn(16'h0A00, 1'b1, 1'b1, 8'h5A, 1'b1, "rw0A00");
    check_access("rw0A00_acc", 2'b01, 11'h100, 1'b0, 8'h5A);
    txn(16'h0A00, 1'b1, 1'b0, 8'h00, 1'b1, "rd0A00");

    // Write immediately followed by a read: one busy cycle, then a normal read.
    txn(16'h0200, 1'b0, 1'b1, 8'h77, 1'b1, "b2b_wr");
    txn(16'h0200, 1'b1, 1'b0, 8'h00, 1'b1, "b2b_rd");

    // Reset in the middle of a read (WAIT state).
    ifc0.ramadr = 16'h0100; ifc0.ramre = 1'b1; ifc0.ramwe = 1'b0; ifc0.cp2en = 1'b1;
    @(posedge cp2); #1;
    @(posedge cp2); #1;
    chk("prerst_cpuwait", 32'(ifc0.cpuwait), 32'd1);
    chk("prerst_dbusin",  32'(ifc0.dbusin),  32'(last_rd));
    ireset = 1'b1; #1;
    chk("midrst_cpuwait", 32'(ifc0.cpuwait), 32'd0);
    chk("midrst_cen",     32'(ifc0.bank_cen), 32'h3);
    chk("midrst_dbusin",  32'(ifc0.dbusin),  32'h00);
    ifc0.ramre = 1'b0;
    @(posedge cp2); #1;
    ireset = 1'b0; last_rd = 8'h00; prev_wr = 1'b0;
    txn(16'h0100, 1'b1, 1'b0, 8'h00, 1'b1, "postrst_rd");

    // Reset during the ACCESS cycle of a write must not commit it.
    ifc0.ramadr = 16'h0100; ifc0.ramre = 1'b0; ifc0.ramwe = 1'b1; ifc0.dbusout = 8'hC3;
    @(posedge cp2); #1;
    chk("pw_cen_access", 32'(ifc0.bank_cen), 32'h2);
    ireset = 1'b1; #1;
    chk("pw_cen_reset", 32'(ifc0.bank_cen), 32'h3);
    ifc0.ramwe = 1'b0;
    @(posedge cp2); #1;
    ireset = 1'b0; last_rd = 8'h00; prev_wr = 1'b0;
    txn(16'h0100, 1'b1, 1'b0, 8'h00, 1'b1, "pw_readback");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: adr = 16'h0100 + 16'($urandom_range(0, 15));
        4, 5:       adr = 16'h08F8 + 16'($urandom_range(0, 15));
        6, 7:       adr = 16'h0100 + 16'($urandom_range(0, 4095));
        8:          adr = 16'($urandom_range(0, 255));
        default:    adr = 16'h1100 + 16'($urandom_range(0, 16'hEEFF));
      endcase
      kind = int'($urandom_range(0, 2));
      re   = (kind != 1);
      we   = (kind != 0);
      wd   = 8'($urandom_range(0, 255));
      en   = ($urandom_range(0, 9) != 0);
      txn(adr, re, we, wd, en, "rnd");
    end

    // WAIT_STATES=3 instance.
    do_access(1, 16'h0300, 1'b0, 1'b1, 8'h9E, 1'b1, stall, rd, rv, ok);
    chk("ws3_wr_stall", 32'(stall), 32'd0);
    @(posedge cp2); #1;
    do_access(1, 16'h0300, 1'b1, 1'b0, 8'h00, 1'b1, stall, rd, rv, ok);
    chk("ws3_rd_done",  32'(ok),    32'd1);
    chk("ws3_rd_stall", 32'(stall), 32'(2 + WS1));
    chk("ws3_rd_data",  32'(rd),    32'h9E);
    chk("ws3_rd_valid", 32'(rv),    32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avr_dmem_bank_ctrl.md
Name: avr_dmem_bank_ctrl

Overview:
Parametrised data-memory controller between the AVR core data bus (ramadr/ramre/ramwe/dbusout/dbusin/cpuwait) and NUM_BANKS single-port synchronous SRAM macros with active-low CEN/WEN.
- Decodes the RAM window starting at RAM_BASE.
- Selects a bank and rebases the address.
- Sequences each access through a small FSM, stalling the core via cpuwait for configurable read wait states.
- Replaces the fixed single-bank, fixed-offset, zero-wait SRAM hookup in the core top level.

Parameters:
- RAM_BASE, 256, first data-space address mapped to SRAM.
- BANK_AW, 11, address bits per bank (bank depth = 2^BANK_AW bytes).
- NUM_BANKS, 2, number of SRAM banks (1..8).
- WAIT_STATES, 1, extra read cycles before data capture (1..7; 0 is illegal and is rejected by an elaboration check).

Ports:
- cp2 in 1: clock; banks are also clocked on the cp2 rising edge.
- ireset in 1: asynchronous reset, active-high.
- cp2en in 1: core clock enable; requests are accepted only when high.
- ramadr in 16: core data address.
- ramre in 1: core read strobe.
- ramwe in 1: core write strobe.
- dbusout in 8: core write data.
- dbusin out 8: read data to core.
- rd_valid out 1: dbusin carries fresh SRAM read data this cycle.
- cpuwait out 1: core stall request.
- bank_cen out NUM_BANKS: per-bank chip enable, active-low.
- bank_wen out 1: shared write enable, active-low.
- bank_a out BANK_AW: shared bank address.
- bank_d out 8: shared bank write data.
- bank_q in 8*NUM_BANKS: bank read data; bank i occupies bits [8i+7:8i].

Behaviour:
- Reset values: state=IDLE, cpuwait=0, rd_valid=0, dbusin=8'h00, bank_cen=all 1, bank_wen=1, bank_a=0, bank_d=0.
- in_range is true when RAM_BASE <= ramadr < RAM_BASE + NUM_BANKS*2^BANK_AW. Compute it in 17 bits so there is no wrap at 16'hFFFF.
- off = ramadr - RAM_BASE.
- bank = off >> BANK_AW; bank_a = off[BANK_AW-1:0].
- req = cp2en & (ramre | ramwe) & in_range. If ramre and ramwe are both high, the access is a write.
- Out-of-range or cp2en=0 requests: ignored, no stall, no bank activity.
- FSM states: IDLE, ACCESS, WAIT, DONE.
  - IDLE: on req, register bank, bank_a, we and dbusout; go to ACCESS. cpuwait is combinationally 1 in the accept cycle for reads and 0 for writes.
  - ACCESS: drive bank_cen[bank]=0 for exactly one cycle; bank_wen=~we; bank_d=the registered data.
    - For a write: next state is IDLE, cpuwait=0.
    - For a read: next state is WAIT with counter=WAIT_STATES, cpuwait=1.
  - WAIT: cpuwait=1; decrement the counter. On the cycle where counter==1, capture bank_q[bank] into dbusin and go to DONE.
  - DONE: cpuwait=0, rd_valid=1 for one cycle. No new request is accepted in DONE because the core's ramre is still the completed access. Next state is IDLE.
- Read stall: the core sees cpuwait high for 2+WAIT_STATES consecutive cycles, and dbusin is valid in the first cycle with cpuwait low.
- Write: zero stall. The bank write occurs on the edge ending the ACCESS cycle.
- Back-to-back requests: a req arriving while the FSM is in ACCESS after a write forces cpuwait=1 (busy) and is accepted on return to IDLE.
- Outside ACCESS, all bank_cen are held high and bank_a/bank_d hold their last values.
- dbusin holds its last captured value between reads.
- Reset mid-operation: all state is cleared immediately and asynchronously, bank_cen is deasserted, and no partial write is committed after reset release.

Optional Feature:
DMEM_ERR_LOG_EN
- With the macro defined, extra outputs err_flag (1), err_addr (16) and err_cnt (8) are present.
  - An access with cp2en & (ramre|ramwe) & ~in_range & ramadr >= RAM_BASE sets the sticky err_flag.
  - The first faulting address is latched into err_addr; it is frozen while err_flag=1.
  - err_cnt saturates at 8'hFF.
  - Added input err_clr (1) clears all three synchronously; reset values are 0.
- Without the macro, these ports and logic do not exist and out-of-range accesses are silently ignored.

Test Plan:
- Reset: assert ireset mid-read (state WAIT) -> cpuwait=0, bank_cen=all 1, dbusin=00 immediately; the next read behaves normally.
- Write then read with defaults:
  - Write 8'hA5 at ramadr=16'h0100 -> bank_cen=2'b10, bank_a=0, bank_wen=0 in the cycle after accept, no stall.
  - Read at 16'h0100 -> cpuwait high for 3 cycles, then dbusin=A5, rd_valid=1.
- Bank boundary: write at 16'h08FF (bank0, a=7FF) and at 16'h0900 (bank1, a=000) -> the correct single bank_cen goes low each time.
- Out of range: reads at 16'h00FF and 16'h1100 -> no cpuwait and no bank_cen activity. With DMEM_ERR_LOG_EN, err_addr=1100 and err_cnt=1.
- WAIT_STATES=3: read -> exactly 5 stall cycles, then data valid.
- Simultaneous events: ramre=ramwe=1 -> treated as a write. A write followed by a read request in the next cycle -> one busy stall cycle, then the normal read sequence.
